// File: rtl/multicycle_controller.sv
// Main control FSM for a multicycle RV32I-subset core (lw, sw, R-type, I-type ALU, beq, jal).
// Latency: Moore outputs decoded from the state register. pc_write and ir_write also follow zero and mem_ready in the same cycle.
// Backpressure: mem_ready=0 holds FETCH, MEMREAD and MEMWRITE. A mem_ready pulse in any other state is ignored.
//
// Ports: clk, reset_n (async, active-low); op, zero, mem_ready in;
//        datapath enables (pc_write, mem_write, ir_write, reg_write), mux selects
//        (adr_src, result_src, alu_src_a, alu_src_b), alu_op, imm_src, illegal, state out.
module multicycle_controller #(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] imm_src,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RTYP = 7'b0110011;
    localparam logic [6:0] OP_ITYP = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t cur;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur <= S_FETCH;
        end else begin
            case (cur)
                S_FETCH:    if (mem_ready) cur <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: cur <= S_MEMADR;
                        OP_RTYP:      cur <= S_EXECUTER;
                        OP_ITYP:      cur <= S_EXECUTEI;
                        OP_BEQ:       cur <= S_BEQ;
                        OP_JAL:       cur <= S_JAL;
                        default:      cur <= TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
                    endcase
                end
                // op is held by the instruction register, so anything other than
                // lw/sw here means corrupted state; recover by refetching.
                S_MEMADR: begin
                    if (op == OP_LW)      cur <= S_MEMREAD;
                    else if (op == OP_SW) cur <= S_MEMWRITE;
                    else                  cur <= S_FETCH;
                end
                S_MEMREAD:  if (mem_ready) cur <= S_MEMWB;
                S_MEMWB:    cur <= S_FETCH;
                S_MEMWRITE: if (mem_ready) cur <= S_FETCH;
                S_EXECUTER: cur <= S_ALUWB;
                S_EXECUTEI: cur <= S_ALUWB;
                S_ALUWB:    cur <= S_FETCH;
                S_BEQ:      cur <= S_FETCH;
                S_JAL:      cur <= S_ALUWB;
                S_TRAP:     cur <= S_TRAP;
                default:    cur <= S_FETCH;
            endcase
        end
    end

    // Raw (pre-reset-gating) state decode.
    logic pc_update, branch, mem_write_raw, ir_write_raw, reg_write_raw;

    always_comb begin
        pc_update     = 1'b0;
        branch        = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        adr_src       = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        illegal       = 1'b0;
        case (cur)
            S_FETCH: begin
                // PC+4 is computed every FETCH cycle but committed only when the
                // instruction word actually arrives.
                alu_src_b    = 2'b10;
                result_src   = 2'b10;
                ir_write_raw = mem_ready;
                pc_update    = mem_ready;
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src    = 2'b01;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
            end
            S_JAL: begin
                // OldPC+4 goes through the ALU into ALUOut for the ALUWB write.
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are gated by reset_n so nothing pulses while reset is held,
    // even in FETCH where ir_write/pc_write follow mem_ready.
    assign pc_write  = reset_n & (pc_update | (branch & zero));
    assign mem_write = reset_n & mem_write_raw;
    assign ir_write  = reset_n & ir_write_raw;
    assign reg_write = reset_n & reg_write_raw;
    assign state     = cur;

    always_comb begin
        case (op)
            OP_LW, OP_ITYP: imm_src = 2'b00;
            OP_SW:          imm_src = 2'b01;
            OP_BEQ:         imm_src = 2'b10;
            OP_JAL:         imm_src = 2'b11;
            default:        imm_src = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller.
// Latency: one table row per clock; outputs sampled 1ns after the falling edge.
// Backpressure: mem_ready is driven per row to create wait states.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;

    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
    logic [3:0] state;

    logic       n_pc_write, n_adr_src, n_mem_write, n_ir_write, n_reg_write, n_illegal;
    logic [1:0] n_result_src, n_alu_src_a, n_alu_src_b, n_alu_op, n_imm_src;
    logic [3:0] n_state;

    always #5 clk = ~clk;

    multicycle_controller #(.TRAP_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .imm_src(imm_src), .illegal(illegal), .state(state)
    );

    multicycle_controller #(.TRAP_ON_ILLEGAL(1'b0)) dut_nop (
        .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_write(n_pc_write), .adr_src(n_adr_src), .mem_write(n_mem_write),
        .ir_write(n_ir_write), .reg_write(n_reg_write), .result_src(n_result_src),
        .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b), .alu_op(n_alu_op),
        .imm_src(n_imm_src), .illegal(n_illegal), .state(n_state)
    );

    // Packed view: {state, pc_write, adr_src, mem_write, ir_write, reg_write,
    //               result_src, alu_src_a, alu_src_b, alu_op, imm_src, illegal}
    logic [19:0] got;
    assign got = {state, pc_write, adr_src, mem_write, ir_write, reg_write,
                  result_src, alu_src_a, alu_src_b, alu_op, imm_src, illegal};

    typedef struct {
        logic [6:0]  op;
        logic        zero;
        logic        mem_ready;
        logic [19:0] exp;
    } vec_t;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RT   = 7'b0110011;
    localparam logic [6:0] IT   = 7'b0010011;
    localparam logic [6:0] BQ   = 7'b1100011;
    localparam logic [6:0] JL   = 7'b1101111;
    localparam logic [6:0] BAD  = 7'b1111111;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    function automatic vec_t mk(input logic [6:0] o, input logic z, input logic mr,
                                input logic [3:0] st, input logic pcw, input logic adr,
                                input logic mw, input logic irw, input logic rw,
                                input logic [1:0] rs, input logic [1:0] a,
                                input logic [1:0] b, input logic [1:0] aop,
                                input logic [1:0] imm, input logic ill);
        vec_t v;
        v.op = o;
        v.zero = z;
        v.mem_ready = mr;
        v.exp = {st, pcw, adr, mw, irw, rw, rs, a, b, aop, imm, ill};
        return v;
    endfunction

    task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        //                  op  z  mr  st    pcw adr mw irw rw  rs     a      b      aop    imm    ill
        // lw, no waits: 0,1,2,3,4
        tbl.push_back(mk(LW, 0, 1, 4'd0,  1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0));
        tbl.push_back(mk(LW, 0, 1, 4'd1,  0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0));
        tbl.push_back(mk(LW, 0, 1, 4'd2,  0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 0));
        tbl.push_back(mk(LW, 0, 1, 4'd3,  0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        tbl.push_back(mk(LW, 0, 1, 4'd4,  0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        // lw, 2 waits in FETCH (zero=1 must not write PC), 3 waits in MEMREAD: 10 cycles
        tbl.push_back(mk(LW, 1, 0, 4'd0,  0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0));
        tbl.push_back(mk(LW, 1, 0, 4'd0,  0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0));
        tbl.push_back(mk(LW, 0, 1, 4'd0,  1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0));
        tbl.push_back(mk(LW, 0, 0, 4'd1,  0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0));
        tbl.push_back(mk(LW, 0, 0, 4'd2,  0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 0));
        tbl.push_back(mk(LW, 0, 0, 4'd3,  0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        tbl.push_back(mk(LW, 0, 0, 4'd3,  0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        tbl.push_back(mk(LW, 0, 0, 4'd3,  0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        tbl.push_back(mk(LW, 0, 1, 4'd3,  0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        tbl.push_back(mk(LW, 0, 0, 4'd4,  0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        // sw, 1 wait in MEMWRITE
        tbl.push_back(mk(SW, 0, 1, 4'd0,  1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 0));
        tbl.push_back(mk(SW, 0, 1, 4'd1,  0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 0));
        tbl.push_back(mk(SW, 0, 1, 4'd2,  0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b01, 0));
        tbl.push_back(mk(SW, 0, 0, 4'd5,  0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0));
        tbl.push_back(mk(SW, 0, 1, 4'd5,  0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0));
        // beq taken
        tbl.push_back(mk(BQ, 0, 1, 4'd0,  1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 0));
        tbl.push_back(mk(BQ, 1, 1, 4'd1,  0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 0));
        tbl.push_back(mk(BQ, 1, 1, 4'd9,  1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10, 0));
        // beq not taken
        tbl.push_back(mk(BQ, 1, 1, 4'd0,  1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 0));
        tbl.push_back(mk(BQ, 0, 1, 4'd1,  0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 0));
        tbl.push_back(mk(BQ, 0, 1, 4'd9,  0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10, 0));
        // R-type; mem_ready low outside wait states has no effect
        tbl.push_back(mk(RT, 0, 1, 4'd0,  1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0));
        tbl.push_back(mk(RT, 0, 0, 4'd1,  0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0));
        tbl.push_back(mk(RT, 0, 0, 4'd6,  0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 0));
        tbl.push_back(mk(RT, 0, 0, 4'd8,  0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        // I-type
        tbl.push_back(mk(IT, 0, 1, 4'd0,  1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0));
        tbl.push_back(mk(IT, 0, 1, 4'd1,  0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0));
        tbl.push_back(mk(IT, 0, 1, 4'd7,  0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 0));
        tbl.push_back(mk(IT, 0, 1, 4'd8,  0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        // jal: 0,1,10,8
        tbl.push_back(mk(JL, 0, 1, 4'd0,  1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b11, 0));
        tbl.push_back(mk(JL, 0, 1, 4'd1,  0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b11, 0));
        tbl.push_back(mk(JL, 0, 1, 4'd10, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 2'b11, 0));
        tbl.push_back(mk(JL, 0, 1, 4'd8,  0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 0));
        // illegal opcode: FETCH, DECODE (then TRAP, checked by hand below)
        tbl.push_back(mk(BAD, 0, 1, 4'd0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0));
        tbl.push_back(mk(BAD, 0, 1, 4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0));

        // Reset held: state FETCH, enables gated even though mem_ready=1.
        reset_n   = 1'b0;
        op        = LW;
        zero      = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_hold", got,
            {4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0});
        @(negedge clk);
        reset_n   = 1'b1;
        mem_ready = 1'b0;
        zero      = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            op        = tbl[i].op;
            zero      = tbl[i].zero;
            mem_ready = tbl[i].mem_ready;
            #1;
            chk($sformatf("row%0d", i), got, tbl[i].exp);
            checks++;
            if (n_state !== tbl[i].exp[19:16]) begin
                errors++;
                $display("FAIL row%0d_nop_state: got %0d expected %0d", i, n_state, tbl[i].exp[19:16]);
            end
        end

        // TRAP holds for 20 cycles regardless of mem_ready/zero.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            op        = BAD;
            zero      = 1'b1;
            mem_ready = 1'b1;
            #1;
            chk($sformatf("trap%0d", k), got,
                {4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1});
            if (k == 0) begin
                checks++;
                if (n_state !== 4'd0) begin
                    errors++;
                    $display("FAIL nop_illegal_to_fetch: got %0d expected 0", n_state);
                end
            end
        end

        // Reset pulse leaves TRAP asynchronously.
        @(negedge clk);
        reset_n = 1'b0;
        op      = LW;
        zero    = 1'b0;
        #1;
        chk("trap_reset", got,
            {4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0});
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("trap_release", got,
            {4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0});

        // lw abandoned by reset in MEMREAD.
        @(negedge clk);
        #1;
        chk("abort_decode", {12'd0, state}, {12'd0, 4'd1});
        @(negedge clk);
        #1;
        chk("abort_memadr", {12'd0, state}, {12'd0, 4'd2});
        @(negedge clk);
        #1;
        chk("abort_memread", {12'd0, state}, {12'd0, 4'd3});
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_reset", got,
            {4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0});
        @(negedge clk);
        #1;
        chk("abort_held", got,
            {4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0});
        reset_n = 1'b1;
        #1;
        chk("abort_release", got,
            {4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0});
        @(negedge clk);
        #1;
        chk("abort_next_decode", {12'd0, state}, {12'd0, 4'd1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
